// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared state encodings, defaults and grant priority for the SDRAM arbiter
package sdram_arb_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARBIT = 3'd1,
        S_AREF  = 3'd2,
        S_WRITE = 3'd3,
        S_READ  = 3'd4
    } arb_state_e;

    localparam int DEF_REF_PERIOD = 750;
    localparam int DEF_CNT_W      = 10;

    // Bit positions in the request vector; higher bit wins
    localparam int REQ_REF = 2;
    localparam int REQ_WR  = 1;
    localparam int REQ_RD  = 0;

    function automatic arb_state_e arb_pick(input logic [2:0] req);
        if (req[REQ_REF]) begin
            return S_AREF;
        end else if (req[REQ_WR]) begin
            return S_WRITE;
        end else if (req[REQ_RD]) begin
            return S_READ;
        end
        return S_ARBIT;
    endfunction

endpackage

// File: rtl/sdram_ref_timer.sv
// rtl/sdram_ref_timer.sv - periodic refresh request generator with sticky overrun detection
module sdram_ref_timer
    import sdram_arb_pkg::*;
#(
    parameter int REF_PERIOD = DEF_REF_PERIOD,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic run_i,
    input  logic clr_req_i,
    output logic ref_req_o,
    output logic ref_overrun_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ref_req_q, ref_req_d;
    logic             overrun_q, overrun_d;
    logic             wrap;

    always_comb begin
        wrap      = run_i && (cnt_q == CNT_W'(REF_PERIOD - 1));
        cnt_d     = (!run_i || wrap) ? '0 : cnt_q + 1'b1;
        // A new wrap re-arms the request even if it is being cleared on the same edge
        ref_req_d = run_i && ((ref_req_q && !clr_req_i) || wrap);
        overrun_d = overrun_q || (wrap && ref_req_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            ref_req_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            ref_req_q <= ref_req_d;
            overrun_q <= overrun_d;
        end
    end

    assign ref_req_o     = ref_req_q;
    assign ref_overrun_o = overrun_q;

endmodule

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - grants the shared SDRAM command bus to refresh, write or read engines
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int REF_PERIOD = DEF_REF_PERIOD,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       init_done,
    input  logic       wr_trig,
    input  logic       rd_trig,
    input  logic       aref_done,
    input  logic       wr_done,
    input  logic       wr_end,
    input  logic       rd_done,
    input  logic       rd_end,
    output logic       aref_en,
    output logic       wr_en,
    output logic       rd_en,
    output logic       ref_pending,
    output logic       busy,
    output logic       ref_overrun,
    output logic [2:0] state
);

    arb_state_e state_q, state_d;
    logic       wr_pend_q, wr_pend_d;
    logic       rd_pend_q, rd_pend_d;
    logic       run;
    logic       clr_req;
    logic       ref_req;

    // Leaving init clears all bookkeeping on the same edge that returns to IDLE
    assign run     = init_done && (state_q != S_IDLE);
    assign clr_req = init_done && (state_q == S_ARBIT) && ref_req;

    sdram_ref_timer #(
        .REF_PERIOD (REF_PERIOD),
        .CNT_W      (CNT_W)
    ) u_ref_timer (
        .clk           (clk),
        .rst           (rst),
        .run_i         (run),
        .clr_req_i     (clr_req),
        .ref_req_o     (ref_req),
        .ref_overrun_o (ref_overrun)
    );

    always_comb begin
        state_d   = state_q;
        wr_pend_d = run && (wr_trig ||
                    (wr_pend_q && !(state_q == S_WRITE && wr_done && wr_end)));
        rd_pend_d = run && (rd_trig ||
                    (rd_pend_q && !(state_q == S_READ && rd_done && rd_end)));
        if (!init_done) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  state_d = S_ARBIT;
                S_ARBIT: state_d = arb_pick({ref_req, wr_pend_q, rd_pend_q});
                S_AREF:  if (aref_done) state_d = S_ARBIT;
                S_WRITE: if (wr_done)   state_d = S_ARBIT;
                S_READ:  if (rd_done)   state_d = S_ARBIT;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wr_pend_q <= 1'b0;
            rd_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_pend_q <= wr_pend_d;
            rd_pend_q <= rd_pend_d;
        end
    end

    assign aref_en     = (state_q == S_AREF);
    assign wr_en       = (state_q == S_WRITE);
    assign rd_en       = (state_q == S_READ);
    assign busy        = aref_en || wr_en || rd_en;
    assign ref_pending = ref_req;
    assign state       = state_q;

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Central command scheduler for the SDRAM controller.
- Sequences three command engines that share one SDRAM command/address bus: auto-refresh, burst write and burst read.
- Accepts single-cycle write/read triggers from the UART command decoder and generates the periodic refresh request internally.
- Grants exactly one engine at a time; priority is refresh > write > read.

Parameters:
- REF_PERIOD, 750, clock cycles between refresh requests (15 us at 50 MHz).
- CNT_W, 10, width of the refresh counter; must satisfy 2^CNT_W > REF_PERIOD.

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  asynchronous, active-high reset.
- init_done  in  1  level; high once SDRAM power-up init is complete.
- wr_trig  in  1  single-cycle pulse requesting a write transfer.
- rd_trig  in  1  single-cycle pulse requesting a read transfer.
- aref_done  in  1  pulse from the refresh engine: refresh finished.
- wr_done  in  1  pulse from the write engine: engine has released the bus.
- wr_end  in  1  sampled with wr_done; 1 = transfer complete, 0 = broken for refresh.
- rd_done  in  1  pulse from the read engine: engine has released the bus.
- rd_end  in  1  sampled with rd_done; same meaning as wr_end.
- aref_en  out  1  level grant to the refresh engine.
- wr_en  out  1  level grant to the write engine.
- rd_en  out  1  level grant to the read engine.
- ref_pending  out  1  refresh is due; the active wr/rd engine must stop at its next burst boundary.
- busy  out  1  high in any state other than IDLE or ARBIT.
- ref_overrun  out  1  sticky error flag.
- state  out  3  current state encoding, for debug.

Behaviour:
- Reset (async): state=IDLE; all outputs 0; refresh counter 0; wr_pend=0, rd_pend=0, ref_req=0.
- IDLE:
  - The refresh counter is held at 0.
  - Triggers are ignored.
  - When init_done=1, go to ARBIT on the next edge.
- Refresh counter:
  - Counts every cycle outside IDLE; wraps REF_PERIOD-1 -> 0.
  - On wrap, sets ref_req.
  - If ref_req is already 1 at wrap, sets ref_overrun (sticky; cleared only by rst).
  - ref_pending = ref_req (registered).
- Trigger latching:
  - wr_trig sets wr_pend; rd_trig sets rd_pend.
  - Repeated triggers while a request is pending merge into it; no count is kept.
  - Triggers are latched in every non-IDLE state, including while the same engine is active.
- ARBIT: evaluate for exactly one cycle, then enter the granted state.
  - ref_req=1 -> AREF.
  - Else wr_pend=1 -> WRITE.
  - Else rd_pend=1 -> READ.
  - Else stay in ARBIT.
  - The grant output rises on the same edge as the state change, i.e. 1 cycle after the request is seen in ARBIT.
- AREF:
  - aref_en=1.
  - ref_req is cleared on the entry edge.
  - On aref_done: aref_en=0 and go to ARBIT, on the same edge.
- WRITE:
  - wr_en=1.
  - On wr_done: wr_en=0 and go to ARBIT.
  - wr_pend is cleared on that edge only if wr_end=1; if wr_end=0 the request stays pending and resumes after the refresh.
  - A wr_trig in the same cycle as wr_done with wr_end=1 leaves wr_pend=1 (the set wins).
- READ: mirror of WRITE, using rd_en, rd_done, rd_end and rd_pend.
- Done pulses that arrive in a state that does not own them are ignored.
- Turnaround: at least one ARBIT cycle between consecutive grants; grants are one-hot at all times.
- wr_trig and rd_trig in the same cycle: both latch; write is served first, then read.
- init_done falling in any non-IDLE state:
  - Go to IDLE on the next edge.
  - Drop all grants.
  - Clear pend/ref_req and the counter.
  - ref_overrun is preserved.

Decomposition:
- Package sdram_arb_pkg:
  - state encodings: IDLE=0, ARBIT=1, AREF=2, WRITE=3, READ=4;
  - default REF_PERIOD;
  - priority constants.
- Sub-module sdram_ref_timer holds the counter, ref_req and overrun logic.
  - Inputs: run, clr_req.
  - Outputs: ref_req, ref_overrun.

Test Plan:
- Reset, then init_done=1 at cycle 5 -> ARBIT at cycle 6; with no triggers, ref_req and aref_en rise at cycle 6+750 (+1 ARBIT cycle); aref_done 4 cycles later -> back to ARBIT.
- wr_trig and rd_trig in the same cycle -> wr_en first; wr_done/wr_end=1 -> one ARBIT cycle -> rd_en; rd_done -> rd_pend=0 and state=ARBIT.
- WRITE active when the refresh counter wraps -> ref_pending=1; engine returns wr_done with wr_end=0 -> AREF granted next, then WRITE re-granted with wr_pend still 1.
- Hold WRITE with no wr_done for 1500 cycles -> ref_overrun=1 at the second wrap and stays set through later transactions until rst.
- wr_trig coincident with wr_done/wr_end=1 -> a second WRITE grant follows after one ARBIT cycle.
- Assert rst and separately drop init_done mid-READ -> rd_en=0 immediately (rst) or on the next edge (init_done); state=IDLE; pend flags cleared; the counter restarts from 0 once init_done returns.
